// File: rtl/gpi_periph.sv
`default_nettype none
// ============================================================================
//  Module   : gpi_periph
//  Purpose  : Memory-mapped general-purpose input port. External pins pass
//             through a 2-flop synchronizer and a per-pin debounce filter.
//             Rising and falling edges of the debounced level are latched in
//             write-1-to-clear event registers that drive a level interrupt.
//  Ports    : clk       - system clock, all logic on posedge
//             rst       - synchronous active-high reset
//             address   - 10-bit bus byte address (full compare)
//             data_in   - 8-bit bus write data
//             write     - bus write strobe
//             read      - bus read strobe
//             pins      - asynchronous external inputs [WIDTH-1:0]
//             data_out  - registered read data (1-cycle latency)
//             irq       - level interrupt request
//  Register map (offsets from BASE_ADDR):
//             +0 STATE (RO), +4 RISE (W1C), +8 FALL (W1C), +C IRQ_EN (RW)
//  Revision : 1.0 - initial release
// ============================================================================
module gpi_periph #(
    parameter int         WIDTH           = 8,
    parameter int         DEBOUNCE_CYCLES = 16,
    parameter logic [9:0] BASE_ADDR       = 10'h54
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [9:0]       address,
    input  logic [7:0]       data_in,
    input  logic             write,
    input  logic             read,
    input  logic [WIDTH-1:0] pins,
    output logic [7:0]       data_out,
    output logic             irq
);

    localparam int              c_CW        = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CW-1:0] c_CNT_LAST  = c_CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE   = c_CW'(1);

    localparam logic [9:0] c_ADDR_STATE  = BASE_ADDR;
    localparam logic [9:0] c_ADDR_RISE   = BASE_ADDR + 10'd4;
    localparam logic [9:0] c_ADDR_FALL   = BASE_ADDR + 10'd8;
    localparam logic [9:0] c_ADDR_IRQ_EN = BASE_ADDR + 10'd12;

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic [WIDTH-1:0] r_irq_en;
    logic [c_CW-1:0]  r_cnt [WIDTH];

    logic [WIDTH-1:0] w_state_nxt;
    logic [c_CW-1:0]  w_cnt_nxt [WIDTH];
    logic [WIDTH-1:0] w_rise_set;
    logic [WIDTH-1:0] w_fall_set;
    logic [WIDTH-1:0] w_clr_bits;
    logic             w_sel_state;
    logic             w_sel_rise;
    logic             w_sel_fall;
    logic             w_sel_irq_en;
    logic [7:0]       w_rd_data;

    // Debounce: a pin's counter runs only while the synchronized level
    // disagrees with the accepted level. The compare uses >= so a counter
    // can never step past the acceptance point, i.e. it never wraps.
    always_comb begin
        w_state_nxt = r_state;
        for (int i = 0; i < WIDTH; i++) begin
            w_cnt_nxt[i] = '0;
            if (r_sync2[i] != r_state[i]) begin
                if (r_cnt[i] >= c_CNT_LAST) begin
                    w_state_nxt[i] = r_sync2[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + c_CNT_ONE;
                end
            end
        end
    end

    assign w_rise_set = w_state_nxt & ~r_state;
    assign w_fall_set = ~w_state_nxt & r_state;
    assign w_clr_bits = data_in[WIDTH-1:0];

    assign w_sel_state  = (address == c_ADDR_STATE);
    assign w_sel_rise   = (address == c_ADDR_RISE);
    assign w_sel_fall   = (address == c_ADDR_FALL);
    assign w_sel_irq_en = (address == c_ADDR_IRQ_EN);

    // Read mux; narrow registers are zero-extended to the 8-bit bus.
    always_comb begin
        w_rd_data = '0;
        if (w_sel_state) begin
            w_rd_data[WIDTH-1:0] = r_state;
        end else if (w_sel_rise) begin
            w_rd_data[WIDTH-1:0] = r_rise;
        end else if (w_sel_fall) begin
            w_rd_data[WIDTH-1:0] = r_fall;
        end else if (w_sel_irq_en) begin
            w_rd_data[WIDTH-1:0] = r_irq_en;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_state  <= '0;
            r_rise   <= '0;
            r_fall   <= '0;
            r_irq_en <= '0;
            data_out <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= pins;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end

            // Set is OR-ed after the clear so a same-edge event survives.
            if (write && w_sel_rise) begin
                r_rise <= (r_rise & ~w_clr_bits) | w_rise_set;
            end else begin
                r_rise <= r_rise | w_rise_set;
            end
            if (write && w_sel_fall) begin
                r_fall <= (r_fall & ~w_clr_bits) | w_fall_set;
            end else begin
                r_fall <= r_fall | w_fall_set;
            end

            if (write && w_sel_irq_en) begin
                r_irq_en <= data_in[WIDTH-1:0];
            end

            // Reads sample pre-write register values, so a same-edge
            // read/write returns the old contents.
            if (read) begin
                data_out <= w_rd_data;
            end
        end
    end

    // Built only from flops: no combinational path from bus or pins.
    assign irq = |((r_rise | r_fall) & r_irq_en);

endmodule
`default_nettype wire
